// File: rtl/sram_axi4_rd_dma_if.sv
// Signal bundle between the read-DMA, the SRAM AXI4 slave (AR/R), the
// command source and the downstream stream consumer.
interface sram_axi4_rd_dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  // command
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [8:0]        i_cmd_beats;
  // AXI4 read address
  logic [ADDR_W-1:0] o_araddr;
  logic [7:0]        o_arlen;
  logic [2:0]        o_arsize;
  logic [1:0]        o_arburst;
  logic [3:0]        o_arid;
  logic              o_arvalid;
  logic              i_arready;
  // AXI4 read data
  logic [DATA_W-1:0] i_rdata;
  logic [1:0]        i_rresp;
  logic              i_rlast;
  logic              i_rvalid;
  logic              o_rready;
  // output stream
  logic [DATA_W-1:0] o_dat_data;
  logic              o_dat_last;
  logic              o_dat_valid;
  logic              i_dat_ready;
  // status
  logic              o_done;
  logic              o_err;

  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_beats,
    output o_cmd_ready,
    output o_araddr, o_arlen, o_arsize, o_arburst, o_arid, o_arvalid,
    input  i_arready,
    input  i_rdata, i_rresp, i_rlast, i_rvalid,
    output o_rready,
    output o_dat_data, o_dat_last, o_dat_valid,
    input  i_dat_ready,
    output o_done, o_err
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_beats,
    input  o_cmd_ready,
    input  o_araddr, o_arlen, o_arsize, o_arburst, o_arid, o_arvalid,
    output i_arready,
    output i_rdata, i_rresp, i_rlast, i_rvalid,
    input  o_rready,
    input  o_dat_data, o_dat_last, o_dat_valid,
    output i_dat_ready,
    input  o_done, o_err
  );
endinterface

// File: rtl/sram_axi4_rd_dma.sv
// AXI4 read-burst DMA: splits one command into INCR bursts of <= MAX_BURST
// beats and streams the returned data out with zero added latency.
module sram_axi4_rd_dma #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 64,
  parameter int          MAX_BURST = 16,
  parameter logic [3:0]  ID        = 4'd1
) (
  input  logic               i_aclk,
  input  logic               i_areset,
  sram_axi4_rd_dma_if.master bus
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BEAT_BYTES);
  localparam logic [8:0]        MAX_BEATS = 9'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        rem_q;
  logic [8:0]        bcnt_q;
  logic [7:0]        arlen_q;
  logic              err_q;

  logic cmd_ready, arvalid, rready, dat_valid, done;
  logic r_beat, burst_end, beat_err;

  // AXI len field for the next burst given the beats still owed.
  function automatic logic [7:0] burst_len(input logic [8:0] rem);
    logic [8:0] n;
    n = (rem > MAX_BEATS) ? MAX_BEATS : rem;
    return 8'(n - 9'd1);
  endfunction

  assign r_beat    = (state_q == R) && bus.i_rvalid && bus.i_dat_ready;
  assign burst_end = r_beat && (bcnt_q == 9'd1);
  // rlast must coincide exactly with the counter's final beat
  assign beat_err  = (bus.i_rresp != 2'b00) || (bus.i_rlast != (bcnt_q == 9'd1));

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    dat_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.i_cmd_valid)
          state_d = (bus.i_cmd_beats == 9'd0) ? DONE : AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (bus.i_arready) state_d = R;
      end
      R: begin
        rready    = bus.i_dat_ready;
        dat_valid = bus.i_rvalid;
        if (burst_end) state_d = (rem_q == 9'd1) ? DONE : AR;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      bcnt_q  <= '0;
      arlen_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            addr_q  <= bus.i_cmd_addr;
            rem_q   <= bus.i_cmd_beats;
            arlen_q <= burst_len(bus.i_cmd_beats);
            err_q   <= 1'b0;
          end
        end
        AR: begin
          if (bus.i_arready) bcnt_q <= {1'b0, arlen_q} + 9'd1;
        end
        R: begin
          if (r_beat) begin
            bcnt_q <= bcnt_q - 9'd1;
            rem_q  <= rem_q - 9'd1;
            addr_q <= addr_q + ADDR_INC;
            if (beat_err) err_q <= 1'b1;
            // next burst length is fixed before AR so it stays stable until handshake
            if (burst_end && (rem_q != 9'd1)) arlen_q <= burst_len(rem_q - 9'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_araddr    = addr_q;
  assign bus.o_arlen     = arlen_q;
  assign bus.o_arsize    = 3'($clog2(BEAT_BYTES));
  assign bus.o_arburst   = 2'b01;
  assign bus.o_arid      = ID;
  assign bus.o_arvalid   = arvalid;
  assign bus.o_rready    = rready;
  assign bus.o_dat_data  = bus.i_rdata;
  assign bus.o_dat_last  = (state_q == R) && (rem_q == 9'd1);
  assign bus.o_dat_valid = dat_valid;
  assign bus.o_done      = done;
  assign bus.o_err       = err_q;

endmodule
